// File: rtl/chan_pkg.sv
`default_nettype none
// ============================================================================
// chan_pkg : shared types and constants for the channel error injector
// Rev 1.0
// ============================================================================
package chan_pkg;

    typedef enum logic [1:0] {
        CH_OFF      = 2'd0,
        CH_PERIODIC = 2'd1,
        CH_RANDOM   = 2'd2,
        CH_BURST    = 2'd3
    } chan_mode_t;

    typedef enum logic {
        BS_IDLE  = 1'b0,
        BS_BURST = 1'b1
    } burst_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit indices 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          CNT_W     = 32;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16 : 16-bit Fibonacci LFSR with advance enable and synchronous clear
// Rev 1.0
// ============================================================================
module lfsr16
    import chan_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        clr,
    output logic [15:0] state
);
    // An all-zero state would lock up, so a zero seed is replaced by 1
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else if (clr) begin
            state <= INIT;
        end else if (adv) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/channel_err_inj.sv
`default_nettype none
// ============================================================================
// channel_err_inj : registers encoder symbols and flips masked bits in
// OFF / PERIODIC / RANDOM / BURST modes, with saturating BER counters. Rev 1.0
// ============================================================================
module channel_err_inj
    import chan_pkg::*;
#(
    parameter int          W         = 2,
    parameter int          N         = 4,
    parameter int          P         = 4,
    parameter int          BURST_LEN = 2,
    parameter int          WINDOW    = 256,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     sym_i,
    input  logic [1:0]       mode_i,
    input  logic [W-1:0]     mask_i,
    input  logic             clear_i,
    output logic             valid_o,
    output logic [W-1:0]     sym_o,
    output logic             err_o,
    output logic [CNT_W-1:0] sym_ct_o,
    output logic [CNT_W-1:0] err_sym_ct_o,
    output logic [CNT_W-1:0] bad_bit_ct_o
);
    localparam logic [CNT_W-1:0] PER_THRESH = 32'((1 << P) - BURST_LEN);
    localparam logic [15:0]      RAND_MASK  = 16'((1 << N) - 1);

    logic [15:0]      lfsr;
    logic             accept;
    logic             rand_hit;
    logic             per_hit;
    logic             in_win;
    logic             trig;
    logic             inj;
    logic             flip;
    logic [CNT_W-1:0] mask_bits;
    chan_mode_t       mode;
    burst_state_t     bstate;
    logic [CNT_W-1:0] bc;

    assign mode     = chan_mode_t'(mode_i);
    assign accept   = valid_i && !clear_i;
    assign rand_hit = (lfsr & RAND_MASK) == 16'h0000;
    assign per_hit  = 32'(sym_ct_o[P-1:0]) >= PER_THRESH;
    assign in_win   = (WINDOW == 0) || (sym_ct_o < 32'(WINDOW));

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (accept),
        .clr   (clear_i),
        .state (lfsr)
    );

    always_comb begin
        trig = 1'b0;
        case (mode)
            CH_OFF:      trig = 1'b0;
            CH_PERIODIC: trig = per_hit;
            CH_RANDOM:   trig = rand_hit;
            CH_BURST:    trig = (bstate == BS_BURST) || rand_hit;
            default:     trig = 1'b0;
        endcase
    end

    assign inj  = accept && trig && in_win;
    assign flip = inj && (mask_i != '0);

    always_comb begin
        mask_bits = '0;
        for (int i = 0; i < W; i++) begin
            mask_bits = mask_bits + 32'(mask_i[i]);
        end
    end

    // Burst FSM keeps running past the window end; only the flips are gated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bstate <= BS_IDLE;
            bc     <= '0;
        end else if (clear_i || mode != CH_BURST) begin
            bstate <= BS_IDLE;
            bc     <= '0;
        end else if (accept) begin
            case (bstate)
                BS_IDLE: begin
                    if (rand_hit) begin
                        bc <= 32'(BURST_LEN - 1);
                        if (BURST_LEN > 1) begin
                            bstate <= BS_BURST;
                        end
                    end
                end
                BS_BURST: begin
                    bc <= bc - 32'd1;
                    if (bc == 32'd1) begin
                        bstate <= BS_IDLE;
                    end
                end
                default: bstate <= BS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o      <= 1'b0;
            sym_o        <= '0;
            err_o        <= 1'b0;
            sym_ct_o     <= '0;
            err_sym_ct_o <= '0;
            bad_bit_ct_o <= '0;
        end else begin
            valid_o <= valid_i;
            err_o   <= 1'b0;
            if (clear_i) begin
                sym_ct_o     <= '0;
                err_sym_ct_o <= '0;
                bad_bit_ct_o <= '0;
                if (valid_i) begin
                    sym_o <= sym_i;
                end
            end else if (valid_i) begin
                sym_o    <= sym_i ^ (inj ? mask_i : '0);
                err_o    <= flip;
                sym_ct_o <= sat_add(sym_ct_o, 32'd1);
                if (flip) begin
                    err_sym_ct_o <= sat_add(err_sym_ct_o, 32'd1);
                end
                if (inj) begin
                    bad_bit_ct_o <= sat_add(bad_bit_ct_o, mask_bits);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_err_inj.sv
`default_nettype none
// ============================================================================
// tb_channel_err_inj : randomized bench for channel_err_inj, two instances
// (BURST_LEN=2/WINDOW=256 and BURST_LEN=3/WINDOW=0) against a reference model.
// ============================================================================
module tb_channel_err_inj;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        clear_i;
    logic [1:0]  sym_i;
    logic [1:0]  mode_i;
    logic [1:0]  mask_i;

    logic        vo [2];
    logic [1:0]  so [2];
    logic        eo [2];
    logic [31:0] sc [2];
    logic [31:0] ec [2];
    logic [31:0] bc [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    channel_err_inj #(.W(2), .N(4), .P(4), .BURST_LEN(2), .WINDOW(256), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .mask_i(mask_i), .clear_i(clear_i), .valid_o(vo[0]), .sym_o(so[0]), .err_o(eo[0]),
        .sym_ct_o(sc[0]), .err_sym_ct_o(ec[0]), .bad_bit_ct_o(bc[0])
    );

    channel_err_inj #(.W(2), .N(4), .P(4), .BURST_LEN(3), .WINDOW(0), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .sym_i(sym_i), .mode_i(mode_i),
        .mask_i(mask_i), .clear_i(clear_i), .valid_o(vo[1]), .sym_o(so[1]), .err_o(eo[1]),
        .sym_ct_o(sc[1]), .err_sym_ct_o(ec[1]), .bad_bit_ct_o(bc[1])
    );

    // Reference model state, one slot per instance
    int          ref_bl  [2] = '{2, 3};
    int          ref_win [2] = '{256, 0};
    int unsigned m_cnt   [2];
    int unsigned m_err   [2];
    int unsigned m_bad   [2];
    int unsigned m_left  [2];
    logic [15:0] m_lfsr  [2];
    logic [1:0]  m_sym   [2];
    logic        m_errf  [2];
    logic        m_valid;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_err[k] = 0; m_bad[k] = 0; m_left[k] = 0;
            m_lfsr[k] = 16'hACE1; m_sym[k] = 2'b00; m_errf[k] = 1'b0;
        end
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit trig, inj;
        m_valid = valid_i;
        for (int k = 0; k < 2; k++) begin
            m_errf[k] = 1'b0;
            if (clear_i) begin
                m_cnt[k] = 0; m_err[k] = 0; m_bad[k] = 0; m_left[k] = 0;
                m_lfsr[k] = 16'hACE1;
                if (valid_i) m_sym[k] = sym_i;
            end else begin
                trig = 0;
                if (valid_i) begin
                    case (mode_i)
                        2'd1: trig = (m_cnt[k] % 16) >= (16 - ref_bl[k]);
                        2'd2: trig = (m_lfsr[k] % 16) == 0;
                        2'd3: begin
                            if (m_left[k] > 0) begin
                                trig = 1; m_left[k]--;
                            end else if ((m_lfsr[k] % 16) == 0) begin
                                trig = 1; m_left[k] = ref_bl[k] - 1;
                            end
                        end
                        default: trig = 0;
                    endcase
                    inj = trig && (ref_win[k] == 0 || m_cnt[k] < ref_win[k]);
                    m_sym[k]  = sym_i ^ (inj ? mask_i : 2'b00);
                    m_errf[k] = inj && (mask_i != 0);
                    m_cnt[k]++;
                    if (m_errf[k]) m_err[k]++;
                    if (inj) m_bad[k] += $countones(mask_i);
                    m_lfsr[k] = lfsr_next(m_lfsr[k]);
                end
                if (mode_i != 2'd3) m_left[k] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("valid_o[%0d]", k), 32'(vo[k]), 32'(m_valid));
            check_val($sformatf("sym_o[%0d]", k), 32'(so[k]), 32'(m_sym[k]));
            check_val($sformatf("err_o[%0d]", k), 32'(eo[k]), 32'(m_errf[k]));
            check_val($sformatf("sym_ct[%0d]", k), sc[k], m_cnt[k]);
            check_val($sformatf("err_ct[%0d]", k), ec[k], m_err[k]);
            check_val($sformatf("bad_ct[%0d]", k), bc[k], m_bad[k]);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic [1:0] m,
                        input logic [1:0] mk, input logic c);
        @(negedge clk);
        valid_i = v; sym_i = s; mode_i = m; mask_i = mk; clear_i = c;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        int run;
        int nruns;
        int guard;
        logic [1:0] s;

        rst = 1'b0; valid_i = 0; clear_i = 0; sym_i = 0; mode_i = 0; mask_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // OFF: straight pass-through with one-clock latency
        for (int i = 0; i < 300; i++) step(1, 2'($urandom), 2'd0, 2'b11, 0);
        check_val("off_sym_ct", sc[0], 32'd300);
        check_val("off_err_ct", ec[0], 32'd0);
        check_val("off_bad_ct", bc[0], 32'd0);

        // PERIODIC: phases 14,15 inside the first 256 symbols
        step(0, 2'b00, 2'd0, 2'b00, 1);
        for (int i = 0; i < 300; i++) step(1, 2'($urandom), 2'd1, 2'b10, 0);
        check_val("per_err_ct", ec[0], 32'd32);
        check_val("per_bad_ct", bc[0], 32'd32);

        // RANDOM: dense run then a stretch with idle gaps
        step(0, 2'b00, 2'd2, 2'b11, 1);
        for (int i = 0; i < 4096; i++) step(1, 2'($urandom), 2'd2, 2'b11, 0);
        check_val("rnd_err_ct_model", ec[1], m_err[1]);
        check_val("rnd_bad_twice", bc[1], 2 * ec[1]);
        for (int i = 0; i < 300; i++)
            step(($urandom % 5) != 0, 2'($urandom), 2'd2, 2'($urandom), 0);

        // BURST: every err_o run on the 3-long instance is a multiple of 3
        step(0, 2'b00, 2'd3, 2'b01, 1);
        run = 0; nruns = 0;
        for (int i = 0; i < 600; i++) begin
            step(1, 2'($urandom), 2'd3, 2'(1 + $urandom % 3), 0);
            if (eo[1]) begin
                run++;
            end else if (run > 0) begin
                check_val("burst_run_mod3", 32'(run % 3), 32'd0);
                run = 0; nruns++;
            end
        end
        check_val("burst_seen", 32'(nruns > 0), 32'd1);

        // Switch to OFF in the middle of a burst
        guard = 0;
        do begin
            step(1, 2'($urandom), 2'd3, 2'b11, 0);
            guard++;
        end while (!eo[1] && guard < 300);
        check_val("burst_found", 32'(eo[1]), 32'd1);
        step(1, 2'($urandom), 2'd0, 2'b11, 0);
        check_val("off_after_switch", 32'(eo[1]), 32'd0);

        // Clear with a valid symbol after 100 symbols
        step(0, 2'b00, 2'd2, 2'b11, 1);
        for (int i = 0; i < 100; i++) step(1, 2'($urandom), 2'd2, 2'b11, 0);
        s = 2'($urandom);
        step(1, s, 2'd2, 2'b11, 1);
        check_val("clr_sym_clean", 32'(so[0]), 32'(s));
        check_val("clr_err", 32'(eo[0]), 32'd0);
        check_val("clr_sym_ct", sc[0], 32'd0);
        check_val("clr_err_ct", ec[1], 32'd0);
        for (int i = 0; i < 50; i++) step(1, 2'($urandom), 2'd2, 2'b11, 0);

        // Asynchronous reset in the middle of a burst
        guard = 0;
        do begin
            step(1, 2'($urandom), 2'd3, 2'b11, 0);
            guard++;
        end while (!eo[1] && guard < 300);
        check_val("rst_burst_found", 32'(eo[1]), 32'd1);
        #2;
        rst = 1'b0;
        valid_i = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 60; i++)
            step(($urandom % 4) != 0, 2'($urandom), 2'd3, 2'b11, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/channel_err_inj.md
# channel_err_inj

Parametrised channel model between the convolutional encoder and the Viterbi decoder. Registers each W-bit encoder symbol and optionally flips masked bits according to a runtime-selected mode (off, periodic, random, random-burst), restricted to an initial symbol window. Keeps symbol, corrupted-symbol and flipped-bit counters for bit-error-rate checks against decoder output.

## Interface
- W, 2: symbol width (encoder output bits per clock).
- N, 4: random-mode rate exponent; per-symbol trigger probability 2^-N, 1..16.
- P, 4: periodic-mode period exponent; period 2^P symbols.
- BURST_LEN, 2: corrupted symbols per periodic slot or random burst, 1..2^P.
- WINDOW, 256: injection allowed only while sym_ct_o < WINDOW; 0 = unlimited.
- SEED, 16'hACE1: LFSR reset/clear value; 0 is replaced by 1.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  sym_i valid this cycle.
- sym_i  in  W  encoder symbol.
- mode_i  in  2  0 OFF, 1 PERIODIC, 2 RANDOM, 3 BURST.
- mask_i  in  W  bits XORed on a corrupted symbol.
- clear_i  in  1  synchronous clear of counters, LFSR, burst state.
- valid_o  out  1  registered valid_i.
- sym_o  out  W  registered, possibly corrupted symbol.
- err_o  out  1  sym_o was corrupted.
- sym_ct_o  out  32  symbols accepted since reset/clear.
- err_sym_ct_o  out  32  corrupted symbols.
- bad_bit_ct_o  out  32  total flipped bits.

## Operation
- Accepted symbol: valid_i=1 and clear_i=0. Only accepted symbols advance counters, LFSR, periodic phase and burst state.
- Window: in_win = (WINDOW==0) or (sym_ct_o < WINDOW), evaluated on the pre-increment count.
- Trigger per accepted symbol (inj):
  - OFF: never.
  - PERIODIC: sym_ct_o[P-1:0] >= 2^P − BURST_LEN (the last BURST_LEN slots of each period; P=4, BURST_LEN=2 → phases 14, 15).
  - RANDOM: lfsr[N-1:0]==0, using the current LFSR value.
  - BURST: FSM IDLE/BURST with burst counter bc. IDLE: if lfsr[N-1:0]==0, inject, bc<=BURST_LEN−1, go BURST if BURST_LEN>1. BURST: inject, decrement bc, return IDLE when bc==1. No retrigger inside a burst.
  - Final inj = trigger && in_win. Bursts straddling the window end are truncated; FSM still runs out.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts once per accepted symbol in every mode.
- Corrupt: sym_o <= sym_i ^ (inj ? mask_i : 0); err_o <= inj && (mask_i != 0).
- Counters: sym_ct_o +1 per accepted symbol; err_sym_ct_o +1 when err_o is set; bad_bit_ct_o += popcount(mask_i) when inj. All saturate at 2^32−1, never wrap.
- Mode change: takes effect the next accepted symbol. Leaving BURST mode forces the FSM to IDLE.
- clear_i: counters <= 0, LFSR <= SEED, FSM <= IDLE. With valid_i in the same cycle, clear wins: valid_o=1, sym_o=sym_i unmodified, err_o=0, nothing counted.

## Timing
- Reset values: valid_o=0, sym_o=0, err_o=0, all counters 0, LFSR=SEED, FSM IDLE.
- Latency 1 clock from sym_i to sym_o/valid_o/err_o. Counters update on the same edge as sym_o.
- No backpressure; one symbol per clock sustained.
- valid_i=0: sym_o holds, valid_o=0, err_o=0.
- Reset asserted mid-burst returns to reset values immediately (asynchronous).

## Structure
- Package chan_pkg: mode enum (CH_OFF, CH_PERIODIC, CH_RANDOM, CH_BURST), burst FSM state enum, 16-bit LFSR tap constant, counter width constant 32.
- Sub-module lfsr16 (SEED param, advance enable, clear, 16-bit state out), shareable with stimulus generators.
- Sibling of the encoder and decoder in the tx/rx top. Top wires encoder valid/data in and sym_o/valid_o out to the decoder.

## Test plan
- OFF, 300 symbols, mask 2'b11 -> sym_o == sym_i delayed 1 clock, err_o never set, sym_ct_o=300, err/bad counts 0.
- PERIODIC, P=4, BURST_LEN=2, WINDOW=256, mask 2'b10, 300 symbols -> phases 14, 15 corrupted by bit[1] only. err_sym_ct_o=32, bad_bit_ct_o=32, no flips after symbol 255.
- RANDOM, N=4, SEED default, 4096 symbols, mask 2'b11, WINDOW=0 -> err_sym_ct_o matches reference LFSR model exactly (about 256), bad_bit_ct_o = 2× err_sym_ct_o.
- BURST, BURST_LEN=3 -> every trigger yields exactly 3 consecutive err_o. Switching to OFF mid-burst stops flips the next symbol.
- clear_i with valid_i high after 100 symbols -> that symbol passes clean, counters read 0 the next cycle, LFSR sequence restarts from SEED.
- rst low mid-burst, then released -> all outputs 0, FSM IDLE, first symbols match a fresh-from-reset run.
